multicycle_control: RTL and testbench
=====================================

# multicycle_control

Sequencing controller for the multicycle build of the MIPS processor. Replaces single-cycle `Control` decode with a Moore FSM that walks each instruction through fetch/decode/execute/memory/writeback. It drives the PC, instruction register, shared memory, register file, ALU operand muxes and ALU control. It stalls on a memory ready handshake and counts retired instructions.

## Interface
- `RETIRE_W`, 32, width of retired-instruction counter.
- `clk` in 1: rising-edge clock. Single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `Opcode` in 6: instruction[31:26] from the instruction register.
- `MemReady` in 1: memory completes the current access this cycle.
- `PCWrite`, `BranchEQ`, `BranchNE` out 1: unconditional PC load; PC load if Zero; PC load if !Zero.
- `IorD` out 1: memory address select, 0=PC, 1=ALUOut.
- `MemRead`, `MemWrite` out 1: memory strobes.
- `IRWrite` out 1: instruction register load.
- `RegDst` out 2: write register select, 0=rt, 1=rd, 2=$31.
- `MemtoReg` out 2: write data select, 0=ALUOut, 1=MDR, 2=PC.
- `RegWrite` out 1: register file write.
- `ALUSrcA` out 1: ALU A select, 0=PC, 1=A reg.
- `ALUSrcB` out 2: ALU B select, 0=B reg, 1=const 4, 2=extended imm, 3=sign-ext imm<<2.
- `ExtZero` out 1: immediate extender uses zero extension instead of sign extension.
- `ALUOp` out 3: 000 add, 001 sub, 010 funct (R-type), 011 or, 100 and, 101 lui.
- `PCSource` out 2: 0=ALU result, 1=ALUOut, 2=jump target.
- `IllegalOp` out 1: one-cycle flag for an unsupported opcode.
- `State` out 4: current state encoding, for debug.
- `RetiredCount` out RETIRE_W: number of completed instructions.

## Operation
- Supported opcodes: 0x00 R, 0x02 j, 0x03 jal, 0x04 beq, 0x05 bne, 0x08 addi, 0x0C andi, 0x0D ori, 0x0F lui, 0x23 lw, 0x2B sw.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11.
- Outputs not listed for a state are 0.
- **FETCH**
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=000, PCSource=0.
  - IRWrite=PCWrite=MemReady.
  - Holds in FETCH while !MemReady; goes to DECODE on MemReady.
- **DECODE**
  - Drives ALUSrcA=0, ALUSrcB=3, ALUOp=000, which precomputes the branch target into ALUOut.
  - Next state by opcode: lw/sw→MEM_ADDR; R→R_EXEC; beq/bne→BRANCH; j/jal→JUMP; addi/andi/ori/lui→I_EXEC.
  - Any other opcode: IllegalOp=1 this cycle, next state FETCH, no retire.
- **MEM_ADDR**
  - Drives ALUSrcA=1, ALUSrcB=2, ALUOp=000.
  - Next state MEM_READ for lw, MEM_WRITE for sw.
- **MEM_READ**
  - Drives MemRead=1, IorD=1.
  - Holds while !MemReady, then goes to MEM_WB.
- **MEM_WB**
  - Drives RegDst=0, MemtoReg=1, RegWrite=1.
  - Next state FETCH; retires.
- **MEM_WRITE**
  - Drives MemWrite=1, IorD=1.
  - Holds while !MemReady, then goes to FETCH; retires.
- **R_EXEC**
  - Drives ALUSrcA=1, ALUSrcB=0, ALUOp=010.
  - Next state R_WB.
- **R_WB**
  - Drives RegDst=1, MemtoReg=0, RegWrite=1.
  - Next state FETCH; retires.
- **BRANCH**
  - Drives ALUSrcA=1, ALUSrcB=0, ALUOp=001, PCSource=1.
  - BranchEQ=(Opcode==0x04), BranchNE=(Opcode==0x05).
  - Next state FETCH; retires whether or not the branch is taken.
- **JUMP**
  - Drives PCSource=2, PCWrite=1.
  - For jal only, also drives RegDst=2, MemtoReg=2, RegWrite=1. The PC value written to $31 is the already-incremented PC+4.
  - Next state FETCH; retires.
- **I_EXEC**
  - Drives ALUSrcA=1, ALUSrcB=2.
  - ALUOp: addi 000, ori 011, andi 100, lui 101.
  - ExtZero=1 for andi/ori only.
  - Next state I_WB.
- **I_WB**
  - Drives RegDst=0, MemtoReg=0, RegWrite=1, ExtZero held as in I_EXEC.
  - Next state FETCH; retires.
- **Output logic**
  - All outputs are decoded combinationally from State, Opcode and MemReady.
  - `Opcode` is sampled only in DECODE and later states; the IR holds it stable.
- **RetiredCount**
  - Increments by 1 on each transition from a retiring state to FETCH.
  - Wraps modulo 2^RETIRE_W.

## Timing
- Reset asserted: State=FETCH, RetiredCount=0.
  - PCWrite, IRWrite, MemRead, MemWrite, RegWrite, BranchEQ, BranchNE and IllegalOp forced to 0 combinationally.
  - All other outputs take their FETCH values.
- Reset released: the first edge with MemReady=1 loads the IR and PC.
- Reset asserted mid-instruction aborts it immediately: no retire, and strobes drop in the same cycle.
- Latency with MemReady held at 1:
  - lw 5 cycles.
  - sw, R-type, I-type 4 cycles.
  - beq, bne, j, jal 3 cycles.
  - Illegal opcode 2 cycles.
- Each low cycle of MemReady during FETCH, MEM_READ or MEM_WRITE adds exactly 1 cycle.
- While stalled, all strobes hold their values; PCWrite and IRWrite stay 0 until MemReady=1.
- MemReady is ignored in every state other than FETCH, MEM_READ and MEM_WRITE.
- RetiredCount updates on the same edge that enters FETCH and is visible the following cycle.

## Test plan
- **Reset and fetch stall**
  - Stimulus: reset high for 2 cycles, MemReady=0 for 3 cycles, then 1.
  - Required: State=0 throughout, PCWrite=0 and IRWrite=0 until MemReady rises; RetiredCount=0.
- **R-type sequence**
  - Stimulus: Opcode=0x00, MemReady=1.
  - Required: State sequence 0,1,6,7,0; ALUOp=010 in R_EXEC; RegDst=1, RegWrite=1 in R_WB; RetiredCount 0→1.
- **lw with wait state**
  - Stimulus: Opcode=0x23, MemReady low for 1 cycle in MEM_READ.
  - Required: sequence 0,1,2,3,3,4,0; 6 cycles total; MemtoReg=1 in MEM_WB.
- **beq then jal**
  - Stimulus: Opcode=0x04, then Opcode=0x03.
  - Required: BranchEQ=1, ALUOp=001, PCSource=1 in BRANCH.
  - Required: jal shows RegDst=2, MemtoReg=2, RegWrite=1, PCWrite=1 in JUMP; RetiredCount +2.
- **ori and illegal opcode**
  - Stimulus: Opcode=0x0D, then Opcode=0x3F.
  - Required: ori has ALUOp=011 and ExtZero=1.
  - Required: 0x3F pulses IllegalOp for 1 cycle in DECODE, returns to FETCH, RetiredCount unchanged.
- **Reset mid-sw**
  - Stimulus: assert reset while State=5 with MemReady=0.
  - Required: MemWrite drops in the same cycle, State=0, RetiredCount=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing controller: Moore FSM that walks each instruction
// through fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_control #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          Opcode,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                BranchEQ,
  output logic                BranchNE,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic [1:0]          RegDst,
  output logic [1:0]          MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic                ExtZero,
  output logic [2:0]          ALUOp,
  output logic [1:0]          PCSource,
  output logic                IllegalOp,
  output logic [3:0]          State,
  output logic [RETIRE_W-1:0] RetiredCount
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                retire;

  logic pc_write_raw, beq_raw, bne_raw, mem_read_raw, mem_write_raw;
  logic ir_write_raw, reg_write_raw, illegal_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    pc_write_raw  = 1'b0;
    beq_raw       = 1'b0;
    bne_raw       = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    IorD          = 1'b0;
    RegDst        = 2'd0;
    MemtoReg      = 2'd0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'd0;
    ExtZero       = 1'b0;
    ALUOp         = 3'b000;
    PCSource      = 2'd0;

    unique case (state_q)
      FETCH: begin
        mem_read_raw = 1'b1;
        ALUSrcB      = 2'd1;
        ir_write_raw = MemReady;
        pc_write_raw = MemReady;
        if (MemReady) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'd3;
        unique case (Opcode)
          OP_LW, OP_SW:                      state_d = MEM_ADDR;
          OP_R:                              state_d = R_EXEC;
          OP_BEQ, OP_BNE:                    state_d = BRANCH;
          OP_J, OP_JAL:                      state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  state_d = I_EXEC;
          default: begin
            illegal_raw = 1'b1;
            state_d     = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        state_d = (Opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_read_raw = 1'b1;
        IorD         = 1'b1;
        if (MemReady) state_d = MEM_WB;
      end
      MEM_WB: begin
        MemtoReg      = 2'd1;
        reg_write_raw = 1'b1;
        state_d       = FETCH;
        retire        = 1'b1;
      end
      MEM_WRITE: begin
        mem_write_raw = 1'b1;
        IorD          = 1'b1;
        if (MemReady) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
        state_d = R_WB;
      end
      R_WB: begin
        RegDst        = 2'd1;
        reg_write_raw = 1'b1;
        state_d       = FETCH;
        retire        = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 3'b001;
        PCSource = 2'd1;
        beq_raw  = (Opcode == OP_BEQ);
        bne_raw  = (Opcode == OP_BNE);
        state_d  = FETCH;
        retire   = 1'b1;
      end
      JUMP: begin
        PCSource     = 2'd2;
        pc_write_raw = 1'b1;
        // PC already holds PC+4 from FETCH, which is the jal link value
        if (Opcode == OP_JAL) begin
          RegDst        = 2'd2;
          MemtoReg      = 2'd2;
          reg_write_raw = 1'b1;
        end
        state_d = FETCH;
        retire  = 1'b1;
      end
      I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ExtZero = (Opcode == OP_ANDI) || (Opcode == OP_ORI);
        unique case (Opcode)
          OP_ORI:  ALUOp = 3'b011;
          OP_ANDI: ALUOp = 3'b100;
          OP_LUI:  ALUOp = 3'b101;
          default: ALUOp = 3'b000;
        endcase
        state_d = I_WB;
      end
      I_WB: begin
        reg_write_raw = 1'b1;
        ExtZero       = (Opcode == OP_ANDI) || (Opcode == OP_ORI);
        state_d       = FETCH;
        retire        = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  assign retired_d = retire ? retired_q + RETIRE_W'(1) : retired_q;

  // Strobes are gated by reset so an aborted access stops in the same cycle
  assign PCWrite      = pc_write_raw  & ~reset;
  assign BranchEQ     = beq_raw       & ~reset;
  assign BranchNE     = bne_raw       & ~reset;
  assign MemRead      = mem_read_raw  & ~reset;
  assign MemWrite     = mem_write_raw & ~reset;
  assign IRWrite      = ir_write_raw  & ~reset;
  assign RegWrite     = reg_write_raw & ~reset;
  assign IllegalOp    = illegal_raw   & ~reset;
  assign State        = state_q;
  assign RetiredCount = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors are queued
// by the driver and compared by an independent negedge monitor.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Opcode;
  logic        MemReady;
  logic        PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0]  RegDst, MemtoReg;
  logic        RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        ExtZero;
  logic [2:0]  ALUOp;
  logic [1:0]  PCSource;
  logic        IllegalOp;
  logic [3:0]  State;
  logic [31:0] RetiredCount;

  always #5 clk = ~clk;

  multicycle_control #(.RETIRE_W(32)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .BranchEQ(BranchEQ), .BranchNE(BranchNE), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtZero(ExtZero), .ALUOp(ALUOp), .PCSource(PCSource), .IllegalOp(IllegalOp),
    .State(State), .RetiredCount(RetiredCount)
  );

  // stb = {PCWrite, BranchEQ, BranchNE, MemRead, MemWrite, IRWrite, RegWrite, IllegalOp}
  typedef struct packed {
    logic [3:0]  st;
    logic [7:0]  stb;
    logic        iord;
    logic        srca;
    logic [1:0]  srcb;
    logic [2:0]  aluop;
    logic [1:0]  pcsrc;
    logic [1:0]  regdst;
    logic [1:0]  memtoreg;
    logic        extz;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  function automatic exp_t x(input logic [3:0] st, input logic [7:0] stb,
                             input logic iord, input logic srca, input logic [1:0] srcb,
                             input logic [2:0] aluop, input logic [1:0] pcsrc,
                             input logic [1:0] regdst, input logic [1:0] memtoreg,
                             input logic extz, input logic [31:0] ret);
    exp_t e;
    e = '{st, stb, iord, srca, srcb, aluop, pcsrc, regdst, memtoreg, extz, ret};
    return e;
  endfunction

  task automatic step(input logic r, input logic [5:0] op, input logic mr, input exp_t e);
    @(posedge clk);
    #1;
    reset    = r;
    Opcode   = op;
    MemReady = mr;
    exp_q.push_back(e);
  endtask

  // common FETCH vectors
  function automatic exp_t f_go(input logic [31:0] ret);
    return x(4'd0, 8'b1001_0100, 0, 0, 2'd1, 3'b000, 2'd0, 2'd0, 2'd0, 0, ret);
  endfunction
  function automatic exp_t dec(input logic [31:0] ret);
    return x(4'd1, 8'b0000_0000, 0, 0, 2'd3, 3'b000, 2'd0, 2'd0, 2'd0, 0, ret);
  endfunction

  always @(negedge clk) begin
    exp_t e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{State, {PCWrite, BranchEQ, BranchNE, MemRead, MemWrite, IRWrite, RegWrite, IllegalOp},
            IorD, ALUSrcA, ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg, ExtZero, RetiredCount};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL cycle%0d state/outputs: got st=%0d stb=%b iord=%b a=%b b=%0d op=%b pcs=%0d rd=%0d m2r=%0d ez=%b ret=%0d, want st=%0d stb=%b iord=%b a=%b b=%0d op=%b pcs=%0d rd=%0d m2r=%0d ez=%b ret=%0d",
                    cyc, a.st, a.stb, a.iord, a.srca, a.srcb, a.aluop, a.pcsrc, a.regdst, a.memtoreg, a.extz, a.ret,
                    e.st, e.stb, e.iord, e.srca, e.srcb, e.aluop, e.pcsrc, e.regdst, e.memtoreg, e.extz, e.ret);
    end
  end

  initial begin
    reset = 1'b1; Opcode = 6'h00; MemReady = 1'b0;
    // reset: strobes forced low, FETCH muxes
    step(1, 6'h00, 0, x(0, 8'b0000_0000, 0, 0, 2'd1, 3'b000, 0, 0, 0, 0, 0));
    step(1, 6'h00, 0, x(0, 8'b0000_0000, 0, 0, 2'd1, 3'b000, 0, 0, 0, 0, 0));
    // fetch stall
    repeat (3) step(0, 6'h00, 0, x(0, 8'b0001_0000, 0, 0, 2'd1, 3'b000, 0, 0, 0, 0, 0));
    // R-type
    step(0, 6'h00, 1, f_go(0));
    step(0, 6'h00, 1, dec(0));
    step(0, 6'h00, 1, x(6, 8'b0000_0000, 0, 1, 2'd0, 3'b010, 0, 0, 0, 0, 0));
    step(0, 6'h00, 1, x(7, 8'b0000_0010, 0, 0, 2'd0, 3'b000, 0, 1, 0, 0, 0));
    // lw with one wait state in MEM_READ
    step(0, 6'h23, 1, f_go(1));
    step(0, 6'h23, 1, dec(1));
    step(0, 6'h23, 1, x(2, 8'b0000_0000, 0, 1, 2'd2, 3'b000, 0, 0, 0, 0, 1));
    step(0, 6'h23, 0, x(3, 8'b0001_0000, 1, 0, 2'd0, 3'b000, 0, 0, 0, 0, 1));
    step(0, 6'h23, 1, x(3, 8'b0001_0000, 1, 0, 2'd0, 3'b000, 0, 0, 0, 0, 1));
    step(0, 6'h23, 1, x(4, 8'b0000_0010, 0, 0, 2'd0, 3'b000, 0, 0, 1, 0, 1));
    // beq
    step(0, 6'h04, 1, f_go(2));
    step(0, 6'h04, 1, dec(2));
    step(0, 6'h04, 1, x(8, 8'b0100_0000, 0, 1, 2'd0, 3'b001, 1, 0, 0, 0, 2));
    // jal
    step(0, 6'h03, 1, f_go(3));
    step(0, 6'h03, 1, dec(3));
    step(0, 6'h03, 1, x(9, 8'b1000_0010, 0, 0, 2'd0, 3'b000, 2, 2, 2, 0, 3));
    // ori
    step(0, 6'h0D, 1, f_go(4));
    step(0, 6'h0D, 1, dec(4));
    step(0, 6'h0D, 1, x(10, 8'b0000_0000, 0, 1, 2'd2, 3'b011, 0, 0, 0, 1, 4));
    step(0, 6'h0D, 1, x(11, 8'b0000_0010, 0, 0, 2'd0, 3'b000, 0, 0, 0, 1, 4));
    // illegal opcode: no retire
    step(0, 6'h3F, 1, f_go(5));
    step(0, 6'h3F, 1, x(1, 8'b0000_0001, 0, 0, 2'd3, 3'b000, 0, 0, 0, 0, 5));
    // bne with MemReady low in DECODE (ignored there)
    step(0, 6'h05, 1, f_go(5));
    step(0, 6'h05, 0, dec(5));
    step(0, 6'h05, 0, x(8, 8'b0010_0000, 0, 1, 2'd0, 3'b001, 1, 0, 0, 0, 5));
    // sw with one wait state, completes and retires
    step(0, 6'h2B, 1, f_go(6));
    step(0, 6'h2B, 1, dec(6));
    step(0, 6'h2B, 1, x(2, 8'b0000_0000, 0, 1, 2'd2, 3'b000, 0, 0, 0, 0, 6));
    step(0, 6'h2B, 0, x(5, 8'b0000_1000, 1, 0, 2'd0, 3'b000, 0, 0, 0, 0, 6));
    step(0, 6'h2B, 1, x(5, 8'b0000_1000, 1, 0, 2'd0, 3'b000, 0, 0, 0, 0, 6));
    // andi
    step(0, 6'h0C, 1, f_go(7));
    step(0, 6'h0C, 1, dec(7));
    step(0, 6'h0C, 1, x(10, 8'b0000_0000, 0, 1, 2'd2, 3'b100, 0, 0, 0, 1, 7));
    step(0, 6'h0C, 1, x(11, 8'b0000_0010, 0, 0, 2'd0, 3'b000, 0, 0, 0, 1, 7));
    // sw aborted by reset while stalled in MEM_WRITE
    step(0, 6'h2B, 1, f_go(8));
    step(0, 6'h2B, 1, dec(8));
    step(0, 6'h2B, 1, x(2, 8'b0000_0000, 0, 1, 2'd2, 3'b000, 0, 0, 0, 0, 8));
    step(0, 6'h2B, 0, x(5, 8'b0000_1000, 1, 0, 2'd0, 3'b000, 0, 0, 0, 0, 8));
    step(1, 6'h2B, 0, x(0, 8'b0000_0000, 0, 0, 2'd1, 3'b000, 0, 0, 0, 0, 0));
    step(0, 6'h02, 1, f_go(0));
    // j after reset
    step(0, 6'h02, 1, dec(0));
    step(0, 6'h02, 1, x(9, 8'b1000_0000, 0, 0, 2'd0, 3'b000, 2, 0, 0, 0, 0));
    step(0, 6'h02, 0, x(0, 8'b0001_0000, 0, 0, 2'd1, 3'b000, 0, 0, 0, 0, 1));
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
